// File: rtl/sha256_pkg.sv
// Shared SHA-256 sizes and types, plus the padder's state encoding and constants.
package sha256_pkg;

  localparam int BYTES_IN_CHUNK      = 64;
  localparam int MEM_WORD_BYTES      = 4;
  localparam int NUM_LENGTH_BYTES    = 8;
  localparam int MEM_WORDS_PER_CHUNK = BYTES_IN_CHUNK / MEM_WORD_BYTES;

  typedef logic [BYTES_IN_CHUNK*8-1:0] Chunk;

  typedef enum logic [1:0] {
    FILL,
    SEND,
    EXTRA,
    SEND_FINAL
  } PadState;

  localparam logic [7:0] PAD_MARKER     = 8'h80;
  localparam int         LENGTH_WORD_HI = 14;
  localparam int         LENGTH_WORD_LO = 15;

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream input and chunk-stream output of the padder, bundled for port lists.
interface sha256_padder_if;
  import sha256_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic [2:0]  in_nbytes;

  logic        chunk_valid;
  logic        chunk_ready;
  Chunk        chunk_data;
  logic        chunk_first;
  logic        chunk_last;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, chunk_ready,
    input  in_ready, chunk_valid, chunk_data, chunk_first, chunk_last
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, chunk_ready,
    output in_ready, chunk_valid, chunk_data, chunk_first, chunk_last
  );

endinterface

// File: rtl/sha256_pad_word.sv
// Masks a final message word to its valid bytes and inserts the 0x80 marker right after them.
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [2:0]  in_nbytes,
  output logic [31:0] out_data
);

  genvar gi;
  generate
    for (gi = 0; gi < MEM_WORD_BYTES; gi++) begin : g_byte
      // Byte 0 is the most significant byte of the word.
      assign out_data[31-8*gi -: 8] =
        (3'(gi) < in_nbytes)  ? in_data[31-8*gi -: 8] :
        (3'(gi) == in_nbytes) ? PAD_MARKER : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/sha256_padder.sv
// Collects message words into a 16-word chunk buffer and appends marker, zero fill and bit length.
module sha256_padder
  import sha256_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sha256_padder_if.slave bus
);

  localparam logic [31:0] MARKER_WORD = {PAD_MARKER, 24'h000000};

  PadState     state_q, state_d;
  logic [31:0] words_q [MEM_WORDS_PER_CHUNK];
  logic [31:0] words_d [MEM_WORDS_PER_CHUNK];
  logic [3:0]  widx_q, widx_d;
  logic [60:0] byte_cnt_q, byte_cnt_d;
  logic        first_pend_q, first_pend_d;
  logic        ended_q, ended_d;
  logic        marker_done_q, marker_done_d;
  logic        in_ready_q, in_ready_d;
  logic        chunk_valid_q, chunk_valid_d;
  logic        chunk_first_q, chunk_first_d;
  logic        chunk_last_q, chunk_last_d;

  logic [2:0]  n_eff;
  logic [31:0] pad_word;
  logic [6:0]  last_len;
  logic        word_in;
  logic        chunk_hs;
  Chunk        chunk_w;

  // Out-of-range byte counts on a final word behave like a full word.
  assign n_eff    = (bus.in_nbytes > 3'd4) ? 3'd4 : bus.in_nbytes;
  assign last_len = {1'b0, widx_q, 2'b00} + 7'(n_eff);
  assign word_in  = bus.in_valid && in_ready_q;
  assign chunk_hs = chunk_valid_q && bus.chunk_ready;

  sha256_pad_word u_pad_word (
    .in_data   (bus.in_data),
    .in_nbytes (n_eff),
    .out_data  (pad_word)
  );

  always_comb begin
    state_d       = state_q;
    words_d       = words_q;
    widx_d        = widx_q;
    byte_cnt_d    = byte_cnt_q;
    first_pend_d  = first_pend_q;
    ended_d       = ended_q;
    marker_done_d = marker_done_q;
    chunk_valid_d = chunk_valid_q;
    chunk_first_d = chunk_first_q;
    chunk_last_d  = chunk_last_q;

    case (state_q)
      FILL: begin
        if (word_in && !bus.in_last) begin
          words_d[widx_q] = bus.in_data;
          byte_cnt_d      = byte_cnt_q + 61'd4;
          if (widx_q == 4'(MEM_WORDS_PER_CHUNK - 1)) begin
            state_d       = SEND;
            ended_d       = 1'b0;
            chunk_valid_d = 1'b1;
            chunk_first_d = first_pend_q;
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end else if (word_in) begin
          byte_cnt_d = byte_cnt_q + 61'(n_eff);
          // A full final word pushes the marker into the following slot, if there is one.
          for (int i = 0; i < MEM_WORDS_PER_CHUNK; i++) begin
            if (i == int'(widx_q)) begin
              words_d[i] = pad_word;
            end else if (i > int'(widx_q)) begin
              words_d[i] = (i == int'(widx_q) + 1 && n_eff == 3'd4) ? MARKER_WORD : 32'h0;
            end
          end
          chunk_valid_d = 1'b1;
          chunk_first_d = first_pend_q;
          if (last_len <= 7'd55) begin
            words_d[LENGTH_WORD_HI] = byte_cnt_d[60:29];
            words_d[LENGTH_WORD_LO] = {byte_cnt_d[28:0], 3'b000};
            state_d      = SEND_FINAL;
            chunk_last_d = 1'b1;
          end else begin
            state_d       = SEND;
            ended_d       = 1'b1;
            marker_done_d = (last_len != 7'd64);
          end
        end
      end

      SEND: begin
        if (chunk_hs) begin
          chunk_valid_d = 1'b0;
          chunk_first_d = 1'b0;
          first_pend_d  = 1'b0;
          if (ended_q) begin
            state_d = EXTRA;
          end else begin
            state_d = FILL;
            widx_d  = 4'd0;
          end
        end
      end

      EXTRA: begin
        for (int i = 0; i < MEM_WORDS_PER_CHUNK; i++) begin
          words_d[i] = 32'h0;
        end
        if (!marker_done_q) begin
          words_d[0] = MARKER_WORD;
        end
        words_d[LENGTH_WORD_HI] = byte_cnt_q[60:29];
        words_d[LENGTH_WORD_LO] = {byte_cnt_q[28:0], 3'b000};
        state_d       = SEND_FINAL;
        chunk_valid_d = 1'b1;
        chunk_first_d = first_pend_q;
        chunk_last_d  = 1'b1;
      end

      SEND_FINAL: begin
        if (chunk_hs) begin
          state_d       = FILL;
          chunk_valid_d = 1'b0;
          chunk_first_d = 1'b0;
          chunk_last_d  = 1'b0;
          byte_cnt_d    = 61'd0;
          widx_d        = 4'd0;
          ended_d       = 1'b0;
          first_pend_d  = 1'b1;
        end
      end

      default: state_d = FILL;
    endcase

    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      for (int i = 0; i < MEM_WORDS_PER_CHUNK; i++) begin
        words_q[i] <= 32'h0;
      end
      widx_q        <= 4'd0;
      byte_cnt_q    <= 61'd0;
      first_pend_q  <= 1'b1;
      ended_q       <= 1'b0;
      marker_done_q <= 1'b0;
      in_ready_q    <= 1'b0;
      chunk_valid_q <= 1'b0;
      chunk_first_q <= 1'b0;
      chunk_last_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      words_q       <= words_d;
      widx_q        <= widx_d;
      byte_cnt_q    <= byte_cnt_d;
      first_pend_q  <= first_pend_d;
      ended_q       <= ended_d;
      marker_done_q <= marker_done_d;
      in_ready_q    <= in_ready_d;
      chunk_valid_q <= chunk_valid_d;
      chunk_first_q <= chunk_first_d;
      chunk_last_q  <= chunk_last_d;
    end
  end

  // Buffer word 0 lands in the top 32 bits of the chunk.
  genvar gi;
  generate
    for (gi = 0; gi < MEM_WORDS_PER_CHUNK; gi++) begin : g_pack
      assign chunk_w[(MEM_WORDS_PER_CHUNK-1-gi)*32 +: 32] = words_q[gi];
    end
  endgenerate

  assign bus.in_ready    = in_ready_q;
  assign bus.chunk_valid = chunk_valid_q;
  assign bus.chunk_data  = chunk_w;
  assign bus.chunk_first = chunk_first_q;
  assign bus.chunk_last  = chunk_last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: pad-word table, hand-written corner messages, backpressure, reset, random messages.
module tb_sha256_padder;
  import sha256_pkg::*;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed { Chunk data; logic first; logic last; } rec_t;
  typedef struct packed { logic [31:0] din; logic [2:0] n; logic [31:0] exp; } pw_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  initial forever #5 clk = ~clk;

  sha256_padder_if bus_if();

  sha256_padder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  logic [31:0] pw_data, pw_out;
  logic [2:0]  pw_n;

  sha256_pad_word u_pw (
    .in_data   (pw_data),
    .in_nbytes (pw_n),
    .out_data  (pw_out)
  );

  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t got_q[$];
  int   rdy_mode = 1;
  bit   sending_done = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_chunk(input string name, input Chunk got, input Chunk exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic Chunk put_word(input Chunk v, input int i, input logic [31:0] w);
    Chunk r;
    r = v;
    r[511-32*i -: 32] = w;
    return r;
  endfunction

  // Reference: standard SHA-256 padding of a whole byte string, then cut into 64-byte chunks.
  task automatic expect_model(input bytes_t msg);
    bytes_t      p;
    logic [63:0] bits;
    int          nch;
    Chunk        v;
    p    = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nch = p.size() / 64;
    for (int c = 0; c < nch; c++) begin
      v = '0;
      for (int k = 0; k < 64; k++) v[511-8*k -: 8] = p[c*64 + k];
      exp_q.push_back(rec_t'{data: v, first: (c == 0), last: (c == nch - 1)});
    end
  endtask

  task automatic drive_word(input logic [31:0] w, input bit last, input logic [2:0] nb, input int gap_pct);
    int t;
    bit acc;
    t   = 0;
    acc = 0;
    if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      bus_if.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = w;
    bus_if.in_last   = last;
    bus_if.in_nbytes = nb;
    while (!acc && t < 2000) begin
      acc = bus_if.in_ready;
      @(posedge clk); #1;
      t++;
    end
    bus_if.in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL word_accept: got no in_ready expected accept within 2000 cycles");
    end else if (last) begin
      chk("chunk_valid_latency", 32'(bus_if.chunk_valid), 32'd1);
    end
  endtask

  task automatic send_msg(input bytes_t msg, input bit empty_tail, input int gap_pct);
    int          pos, rem, nb;
    bit          last, done;
    logic [31:0] w;
    pos  = 0;
    done = 0;
    while (!done) begin
      w   = $urandom();
      rem = msg.size() - pos;
      if (rem > 4 || (rem == 4 && empty_tail)) begin
        nb   = 4;
        last = 0;
      end else begin
        nb   = rem;
        last = 1;
      end
      for (int k = 0; k < nb; k++) w[31-8*k -: 8] = msg[pos + k];
      pos += nb;
      drive_word(w, last, last ? 3'(nb) : 3'($urandom_range(0, 7)), gap_pct);
      done = last;
    end
  endtask

  task automatic drain(input string tag);
    int   t;
    rec_t e, g;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_missing: got no chunk expected first=%0b last=%0b", tag, e.first, e.last);
      end else begin
        g = got_q.pop_front();
        chk_chunk({tag, "_data"}, g.data, e.data);
        chk({tag, "_first"}, 32'(g.first), 32'(e.first));
        chk({tag, "_last"}, 32'(g.last), 32'(e.last));
        $display("%s chunk: first=%0b last=%0b word0=%h word15=%h", tag, g.first, g.last,
                 g.data[511:480], g.data[31:0]);
      end
    end
    chk({tag, "_extra_chunks"}, 32'(got_q.size()), 32'd0);
    got_q.delete();
  endtask

  initial begin
    bus_if.chunk_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus_if.chunk_ready = 1'b0;
        1:       bus_if.chunk_ready = 1'b1;
        default: bus_if.chunk_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Capture handshaken chunks and verify a stalled chunk holds still with input stalled.
  initial begin
    bit   pend;
    rec_t held;
    pend = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("hold_valid", 32'(bus_if.chunk_valid), 32'd1);
          chk_chunk("hold_data", bus_if.chunk_data, held.data);
          chk("hold_first", 32'(bus_if.chunk_first), 32'(held.first));
          chk("hold_last", 32'(bus_if.chunk_last), 32'(held.last));
          chk("hold_in_ready", 32'(bus_if.in_ready), 32'd0);
        end
        if (bus_if.chunk_valid && bus_if.chunk_ready)
          got_q.push_back(rec_t'{data: bus_if.chunk_data, first: bus_if.chunk_first, last: bus_if.chunk_last});
        pend = bus_if.chunk_valid && !bus_if.chunk_ready;
        held = rec_t'{data: bus_if.chunk_data, first: bus_if.chunk_first, last: bus_if.chunk_last};
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected simulation end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pw_vec_t pw_tab[7];
    bytes_t  msg, msg2;
    Chunk    v;
    int      lens[8];
    int      t, len;
    bit      et;

    bus_if.in_valid  = 1'b0;
    bus_if.in_data   = 32'h0;
    bus_if.in_last   = 1'b0;
    bus_if.in_nbytes = 3'd0;
    pw_data = 32'h0;
    pw_n    = 3'd0;

    pw_tab[0] = '{32'hAABBCCDD, 3'd0, 32'h80000000};
    pw_tab[1] = '{32'hAABBCCDD, 3'd1, 32'hAA800000};
    pw_tab[2] = '{32'hAABBCCDD, 3'd2, 32'hAABB8000};
    pw_tab[3] = '{32'hAABBCCDD, 3'd3, 32'hAABBCC80};
    pw_tab[4] = '{32'hAABBCCDD, 3'd4, 32'hAABBCCDD};
    pw_tab[5] = '{32'h12345678, 3'd2, 32'h12348000};
    pw_tab[6] = '{32'h616263FF, 3'd3, 32'h61626380};
    for (int i = 0; i < 7; i++) begin
      pw_data = pw_tab[i].din;
      pw_n    = pw_tab[i].n;
      #1;
      chk($sformatf("pad_word_%0d", i), pw_out, pw_tab[i].exp);
      $display("pad_word in=%h n=%0d out=%h", pw_tab[i].din, pw_tab[i].n, pw_out);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("rst_chunk_valid", 32'(bus_if.chunk_valid), 32'd0);
    chk_chunk("rst_chunk_data", bus_if.chunk_data, '0);
    chk("rst_chunk_first", 32'(bus_if.chunk_first), 32'd0);
    chk("rst_chunk_last", 32'(bus_if.chunk_last), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(bus_if.in_ready), 32'd1);

    // "abc"
    rdy_mode = 1;
    msg = '{8'h61, 8'h62, 8'h63};
    v = '0;
    v = put_word(v, 0, 32'h61626380);
    v = put_word(v, 15, 32'h00000018);
    exp_q.push_back(rec_t'{data: v, first: 1'b1, last: 1'b1});
    send_msg(msg, 0, 0);
    drain("abc");

    // Empty message
    msg.delete();
    v = put_word('0, 0, 32'h80000000);
    exp_q.push_back(rec_t'{data: v, first: 1'b1, last: 1'b1});
    send_msg(msg, 0, 0);
    drain("empty");

    // 56 bytes: marker fills word 14, length needs an extra chunk
    msg.delete();
    for (int k = 0; k < 56; k++) msg.push_back(8'(k + 1));
    v = '0;
    for (int i = 0; i < 14; i++) v = put_word(v, i, {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
    v = put_word(v, 14, 32'h80000000);
    exp_q.push_back(rec_t'{data: v, first: 1'b1, last: 1'b0});
    exp_q.push_back(rec_t'{data: put_word('0, 15, 32'h000001C0), first: 1'b0, last: 1'b1});
    send_msg(msg, 0, 0);
    drain("len56");

    // 64 bytes: marker and length both in the extra chunk
    msg.delete();
    for (int k = 0; k < 64; k++) msg.push_back(8'(255 - k));
    v = '0;
    for (int i = 0; i < 16; i++) v = put_word(v, i, {msg[4*i], msg[4*i+1], msg[4*i+2], msg[4*i+3]});
    exp_q.push_back(rec_t'{data: v, first: 1'b1, last: 1'b0});
    v = put_word('0, 0, 32'h80000000);
    v = put_word(v, 15, 32'h00000200);
    exp_q.push_back(rec_t'{data: v, first: 1'b0, last: 1'b1});
    send_msg(msg, 0, 0);
    drain("len64");

    // Backpressure with two back-to-back messages
    rdy_mode = 0;
    msg.delete();
    msg2.delete();
    for (int k = 0; k < 80; k++) msg.push_back(8'($urandom()));
    for (int k = 0; k < 10; k++) msg2.push_back(8'($urandom()));
    expect_model(msg);
    expect_model(msg2);
    sending_done = 0;
    fork
      begin
        send_msg(msg, 0, 0);
        send_msg(msg2, 0, 0);
        sending_done = 1;
      end
    join_none
    t = 0;
    while (!bus_if.chunk_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_chunk_valid", 32'(bus_if.chunk_valid), 32'd1);
    v = bus_if.chunk_data;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
      chk_chunk("bp_data_stable", bus_if.chunk_data, v);
    end
    rdy_mode = 1;
    t = 0;
    while (!sending_done && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("bp_send_done", 32'(sending_done), 32'd1);
    drain("backpressure");

    // Reset in the middle of a message, then "abc" again
    for (int i = 0; i < 7; i++) drive_word($urandom(), 1'b0, 3'd4, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_chunk_valid", 32'(bus_if.chunk_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus_if.in_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_no_chunks", 32'(got_q.size()), 32'd0);
    got_q.delete();
    msg = '{8'h61, 8'h62, 8'h63};
    v = '0;
    v = put_word(v, 0, 32'h61626380);
    v = put_word(v, 15, 32'h00000018);
    exp_q.push_back(rec_t'{data: v, first: 1'b1, last: 1'b1});
    send_msg(msg, 0, 0);
    drain("abc_after_rst");

    // Boundary lengths, then random lengths, random gaps and random chunk_ready
    lens = '{55, 57, 60, 63, 64, 119, 120, 128};
    rdy_mode = 2;
    for (int m = 0; m < 28; m++) begin
      len = (m < 8) ? lens[m] : $urandom_range(0, 150);
      msg.delete();
      for (int k = 0; k < len; k++) msg.push_back(8'($urandom()));
      et = (len > 0 && len % 4 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      expect_model(msg);
      send_msg(msg, et, 25);
      drain($sformatf("rand%0d_len%0d", m, len));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_padder.md
# sha256_padder

Message-side front end of the SHA-256 datapath. Accepts an arbitrary-length byte message as a stream of big-endian 32-bit words and emits complete 512-bit `Chunk`s to the compression core. It appends the mandatory 0x80 marker, zero fill and 64-bit big-endian bit length. It flags the first chunk, where the core loads `H`, and the last chunk, where the core produces the digest.

## Interface
- No parameters; sizes come from `sha256_pkg` (`BYTES_IN_CHUNK`, `MEM_WORD_BYTES`, `NUM_LENGTH_BYTES`, `MEM_WORDS_PER_CHUNK`).
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: message word present.
- `in_ready` output 1: padder accepts a word this cycle.
- `in_data` input 32: message bytes, big-endian. Byte 0 is in [31:24].
- `in_last` input 1: final word of the message.
- `in_nbytes` input 3: valid bytes in the word, left-justified. Values 0–4 are legal only with `in_last`; otherwise the word is treated as 4. A value of 0 with `in_last` encodes the empty tail.
- `chunk_valid` output 1: `chunk_data` holds a complete chunk.
- `chunk_ready` input 1: core accepts the chunk.
- `chunk_data` output 512 (`Chunk`): word [15] is chunk word 0, the first in message order.
- `chunk_first` output 1: chunk is the first of its message.
- `chunk_last` output 1: chunk carries the length field.

## Operation
- States (`PadState`):
  - FILL: `in_ready`=1.
  - SEND: emit a data chunk.
  - EXTRA: build the pad-only chunk.
  - SEND_FINAL: emit the chunk carrying the length.
- A single 16-word buffer. `widx` (4 bits) is the next word slot. `byte_cnt` (61 bits) counts message bytes.
- FILL, on accepted word without `in_last`:
  - Store the word at `widx` and add 4 to `byte_cnt`.
  - When `widx`=15, go to SEND; otherwise increment `widx`.
- FILL, on accepted word with `in_last`, where n = `in_nbytes` and L = 4·`widx`+n:
  - Store the masked word, with bytes ≥ n zeroed.
  - If n<4, put 0x80 at byte n of the word.
  - Zero words `widx`+1..15 and add n to `byte_cnt`.
  - If L ≤ 55: write the bit length (`byte_cnt`·8) to words 14 (high) and 15 (low), then go to SEND_FINAL.
  - If 56 ≤ L ≤ 63: go to SEND with `marker_done`=1.
  - If L = 64: go to SEND with `marker_done`=0.
- SEND, on handshake:
  - If the message is not ended, return to FILL with `widx`=0.
  - If the message is ended, go to EXTRA.
- EXTRA, in one cycle:
  - Build all-zero words.
  - Set word 0 = 0x80000000 if `marker_done`=0.
  - Write words 14/15 = length.
  - Go to SEND_FINAL.
- SEND_FINAL, on handshake: reset `byte_cnt` and `widx`, set `first_pend`=1, go to FILL.
- `chunk_first` = `first_pend`, latched at chunk emission. `first_pend` clears after the first chunk handshake.
- `chunk_last`=1 only in SEND_FINAL.
- Bit length is modulo 2^64. `byte_cnt` wraps silently.

## Timing
- Reset values:
  - `in_ready`=0 while `rst`=1, and 1 in the cycle after `rst` falls.
  - `chunk_valid`=0, `chunk_data`=0, `chunk_first`=0, `chunk_last`=0.
  - State FILL, `widx`=0, `byte_cnt`=0, `first_pend`=1.
- A word transfers when `in_valid`&`in_ready`. A chunk transfers when `chunk_valid`&`chunk_ready`.
- `chunk_valid` rises 1 cycle after the 16th word or the last word is accepted. EXTRA adds 1 cycle.
- Once asserted, `chunk_valid` and `chunk_data`/`chunk_first`/`chunk_last` hold stable until handshake. There is no withdrawal.
- `in_ready`=0 in SEND, EXTRA and SEND_FINAL. Input is fully stalled while a chunk is pending.
- After the chunk handshake, `in_ready`=1 the next cycle. Sustained throughput is 16 words per 17 cycles.
- Reset mid-message or with a chunk pending discards everything. `chunk_valid` drops in the cycle after `rst` is sampled.

## Structure
- Add to `sha256_pkg`: `PadState` enum, `PAD_MARKER` = 8'h80, and `LENGTH_WORD_HI`/`LENGTH_WORD_LO` = 14/15.
- Reuse `Chunk`, `BYTES_IN_CHUNK`, `MEM_WORD_BYTES` and `NUM_LENGTH_BYTES` unchanged.
- Sub-module `sha256_pad_word`: combinational. Inputs `in_data` and `in_nbytes`; output is the masked word with the marker inserted. It is unit-tested separately.

## Test plan
- "abc": a single word 0x61626300, `in_nbytes`=3, `in_last`.
  - Expect one chunk with `first`=`last`=1.
  - Word 0 = 0x61626380, words 1–14 = 0, word 15 = 0x00000018.
- Empty message: `in_nbytes`=0, `in_last`.
  - Expect one chunk with word 0 = 0x80000000 and all other words 0, including the length.
- 56-byte message: 14 words, last `in_nbytes`=4.
  - Chunk 1: words 0–13 = data, word 14 = 0x80000000, word 15 = 0, `first`=1, `last`=0.
  - Chunk 2: words 0–14 = 0, word 15 = 0x000001C0, `first`=0, `last`=1.
- 64-byte message: 16 full words.
  - Chunk 1: data only, `first`=1, `last`=0.
  - Chunk 2: word 0 = 0x80000000, word 15 = 0x00000200, `last`=1.
- Backpressure: hold `chunk_ready`=0 for 5 cycles with `in_valid`=1.
  - `chunk_data` is stable, `in_ready`=0, and no word is lost after release.
  - Two back-to-back messages: the second message's first chunk has `chunk_first`=1.
- Reset after 7 words of a message, then send "abc".
  - Output equals the "abc" case exactly, with `chunk_first`=1.
